// File: rtl/spi_master_tx.sv
// SPI mode-0 master that drains a TX FIFO MSB-first and returns each received word
// with a one-cycle valid strobe. Back-to-back words share a single chip-select window.
module spi_master_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_out_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_enable_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output logic                  ss_n_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o
);

  localparam int unsigned DivW = $clog2(CLK_DIV) + 1;
  localparam int unsigned BitW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StSclkLo, StSclkHi, StTrail} state_e;

  state_e                state_q, state_d;
  logic [DivW-1:0]       div_cnt_q, div_cnt_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_shreg_q, tx_shreg_d;
  logic [DATA_WIDTH-1:0] rx_shreg_q, rx_shreg_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  pop;
  logic                  div_done;
  logic                  last_bit;
  logic                  can_pop;
  logic [DATA_WIDTH-1:0] rx_next;

  assign div_done = (div_cnt_q == DivW'(CLK_DIV - 1));
  assign last_bit = (bit_cnt_q == BitW'(DATA_WIDTH - 1));
  assign can_pop  = enable_i & ~fifo_empty_i;
  assign rx_next  = {rx_shreg_q[DATA_WIDTH-2:0], miso_i};

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shreg_d = tx_shreg_q;
    rx_shreg_d = rx_shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        div_cnt_d = '0;
        if (can_pop) begin
          pop        = 1'b1;
          tx_shreg_d = fifo_data_out_i;
          bit_cnt_d  = '0;
          state_d    = StSclkLo;
        end
      end
      StSclkLo: begin
        if (div_done) begin
          div_cnt_d  = '0;
          state_d    = StSclkHi;
          rx_shreg_d = rx_next;
          if (last_bit) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end
      StSclkHi: begin
        if (div_done) begin
          div_cnt_d = '0;
          if (!last_bit) begin
            tx_shreg_d = tx_shreg_q << 1;
            bit_cnt_d  = bit_cnt_q + BitW'(1);
            state_d    = StSclkLo;
          end else if (can_pop) begin
            // Chain the next word without releasing chip select.
            pop        = 1'b1;
            tx_shreg_d = fifo_data_out_i;
            bit_cnt_d  = '0;
            state_d    = StSclkLo;
          end else begin
            state_d = StTrail;
          end
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end
      StTrail: begin
        if (div_done) begin
          div_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      tx_shreg_q <= '0;
      rx_shreg_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shreg_q <= tx_shreg_d;
      rx_shreg_q <= rx_shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // The pop strobe is combinational, so it must be masked while reset is held.
  assign fifo_rd_enable_o = pop & ~rst_i;
  assign ss_n_o           = (state_q == StIdle);
  assign sclk_o           = (state_q == StSclkHi);
  assign busy_o           = (state_q != StIdle);
  assign mosi_o           = ((state_q == StSclkLo) || (state_q == StSclkHi)) ?
                            tx_shreg_q[DATA_WIDTH-1] : 1'b0;
  assign rx_data_o        = rx_data_q;
  assign rx_valid_o       = rx_valid_q;

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
- Acts as the read side of the transmit FIFO: pops bytes with a one-cycle read pulse and shifts them out on mosi.
- Captures miso into a receive byte that is reported with a one-cycle valid pulse.
- Sits between the TX FIFO and the chip pins; chip select stays asserted across back-to-back bytes.

Parameters:
- DATA_WIDTH, 8, bits per SPI word; must match the FIFO data width.
- CLK_DIV, 2, system clock cycles per sclk half-period; must be >= 1, so sclk = clk / (2*CLK_DIV).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active high
- enable  input  1  permits starting or chaining words
- fifo_data_out  input  DATA_WIDTH  FIFO read data; valid only in the cycle fifo_rd_enable=1 and fifo_empty=0
- fifo_empty  input  1  FIFO has no data
- fifo_rd_enable  output  1  one-cycle pop strobe, combinational from state and inputs
- sclk  output  1  SPI clock
- mosi  output  1  serial data out
- miso  input  1  serial data in
- ss_n  output  1  slave select, active low
- rx_data  output  DATA_WIDTH  last received word
- rx_valid  output  1  one-cycle pulse when rx_data updates
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Clocking and reset:
  - Single clock domain. rst is synchronous, active high, and all registers update on the rising edge of clk.
  - Reset values: state=IDLE, ss_n=1, sclk=0, mosi=0, rx_data=0, rx_valid=0, busy=0, div_cnt=0, bit_cnt=0.
  - Reset mid-word aborts immediately. No pop and no rx_valid occur during reset.
- States: IDLE, SCLK_LO, SCLK_HI, TRAIL.
- IDLE:
  - Outputs: ss_n=1, sclk=0.
  - If enable=1 and fifo_empty=0: fifo_rd_enable=1 this cycle, tx_shreg<=fifo_data_out, bit_cnt<=0, div_cnt<=0, next state SCLK_LO.
  - Otherwise no pop.
- SCLK_LO:
  - Outputs: ss_n=0, sclk=0, mosi=tx_shreg[DATA_WIDTH-1].
  - After CLK_DIV cycles (div_cnt==CLK_DIV-1): go to SCLK_HI and shift miso in: rx_shreg<={rx_shreg[DATA_WIDTH-2:0],miso}.
  - If bit_cnt==DATA_WIDTH-1 on this transition: rx_data<={rx_shreg[DATA_WIDTH-2:0],miso} and rx_valid=1 for exactly that cycle.
- SCLK_HI:
  - Outputs: ss_n=0, sclk=1.
  - After CLK_DIV cycles:
    - bit_cnt<DATA_WIDTH-1: tx_shreg shifts left by 1, bit_cnt++, next state SCLK_LO.
    - bit_cnt==DATA_WIDTH-1, enable=1 and fifo_empty=0: fifo_rd_enable=1 this cycle, reload tx_shreg, bit_cnt<=0, next state SCLK_LO. ss_n stays low, giving a gapless chain.
    - bit_cnt==DATA_WIDTH-1 otherwise: next state TRAIL.
- TRAIL:
  - Outputs: ss_n=0, sclk=0.
  - After CLK_DIV cycles go to IDLE. ss_n is high for at least 1 cycle before the next frame.
- Counter rules:
  - div_cnt wraps from CLK_DIV-1 to 0 on every state change, with width $clog2(CLK_DIV)+1.
  - bit_cnt width is $clog2(DATA_WIDTH)+1.
- Word timing:
  - One word takes 2*CLK_DIV*DATA_WIDTH cycles of ss_n low, plus CLK_DIV cycles of TRAIL after the last word.
- Boundary conditions:
  - fifo_rd_enable is never asserted while fifo_empty=1. At most one pop per word.
  - Deasserting enable mid-word completes the current word, then goes to TRAIL.
  - fifo_empty rising mid-word has no effect until the end-of-word decision.
  - Data is popped only at the start of a word. A FIFO write in the same cycle as a pop is the FIFO's concern.

Test Plan:
- CLK_DIV=2, FIFO holds 0xA5, enable=1, miso looped to mosi:
  - exactly one fifo_rd_enable pulse;
  - ss_n low 34 cycles;
  - 8 sclk rising edges;
  - mosi bits 1,0,1,0,0,1,0,1;
  - rx_data=0xA5 with one rx_valid pulse; busy falls after TRAIL.
- FIFO holds 0x3C then 0xC3:
  - two pops, 32 cycles apart;
  - ss_n continuously low 66 cycles;
  - 16 sclk rising edges;
  - rx_valid pulses twice, giving 0x3C then 0xC3.
- fifo_empty=1, enable=1 for 100 cycles -> fifo_rd_enable never 1, ss_n=1, sclk=0, busy=0.
- Two words queued, enable dropped during bit 3 of word 1 -> word 1 completes (rx_valid once), TRAIL, IDLE, only one pop.
- miso tied 1, FIFO holds 0x00 -> mosi constant 0, rx_data=0xFF.
- rst asserted during SCLK_HI of bit 4 -> next cycle ss_n=1, sclk=0, busy=0, rx_valid=0, no pop; a later word with 0x81 transfers cleanly.
